vga_line_fetch_ctrl: RTL and testbench

//  Framebuffer line prefetch controller for the 1920x1080 VGA timing generator.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_line_fetch_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_vga_line_fetch_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared 1920x1080 timing constants, line-fetch geometry and fetch FSM state encoding.
// Pure declarations: no logic, no latency, no flow control.
package vga_pkg;
  localparam int H_DISPLAY    = 1920;
  localparam int H_TOTAL      = 2200;
  localparam int V_DISPLAY    = 1080;
  localparam int V_TOTAL      = 1125;
  localparam int PIX_PER_WORD = 4;
  localparam int WPL          = H_DISPLAY / PIX_PER_WORD;
  localparam int BURST_LEN    = 16;
  localparam int ADDR_W       = 24;
  localparam int DATA_W       = 48;
  localparam logic [ADDR_W-1:0] FB_BASE = '0;

  localparam int NBURST = WPL / BURST_LEN;
  localparam int BCNT_W = $clog2(NBURST);
  localparam int WCNT_W = $clog2(BURST_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/vga_line_fetch_ctrl.sv
// Prefetches visible line N+1 into the ping-pong line buffer while line N scans out; rd_req one cycle after the h==0 trigger.
// Stalls on rd_gnt/rd_valid; a fetch still running at line end sets sticky underrun and the accepted burst is drained.
module vga_line_fetch_ctrl
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [11:0]       h_counter,
  input  logic [10:0]       v_counter,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_gnt,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              lb_we,
  output logic              lb_bank,
  output logic [8:0]        lb_waddr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              rd_bank,
  output logic [8:0]        rd_waddr,
  output logic              fetch_busy,
  output logic              line_done,
  output logic              underrun,
  input  logic              clr_underrun
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [BCNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [8:0]        line_idx_q, line_idx_d;
  logic              bank_q, bank_d;
  logic              lb_we_q, lb_we_d;
  logic [8:0]        lb_waddr_q, lb_waddr_d;
  logic [DATA_W-1:0] lb_wdata_q, lb_wdata_d;
  logic              line_done_q, line_done_d;
  logic              underrun_q, underrun_d;

  logic              trig;
  logic              deadline;
  logic              last_word;
  logic              underrun_set;
  logic [10:0]       tgt_line;
  logic [ADDR_W-1:0] line_start;

  always_comb begin
    trig     = 1'b0;
    tgt_line = '0;
    if (h_counter == 12'd0) begin
      if (v_counter == 11'(V_TOTAL - 1)) begin
        trig     = 1'b1;
        tgt_line = '0;
      end else if (v_counter < 11'(V_DISPLAY - 1)) begin
        trig     = 1'b1;
        tgt_line = v_counter + 11'd1;
      end
    end
  end

  // Pointer is re-derived from the target line so a missed line never skews the frame.
  assign line_start = FB_BASE + ADDR_W'(tgt_line) * ADDR_W'(WPL);
  assign deadline   = (h_counter == 12'(H_TOTAL - 1));
  assign last_word  = (word_cnt_q == WCNT_W'(BURST_LEN - 1));

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    base_d       = base_q;
    burst_cnt_d  = burst_cnt_q;
    word_cnt_d   = word_cnt_q;
    line_idx_d   = line_idx_q;
    bank_d       = bank_q;
    lb_we_d      = 1'b0;
    lb_waddr_d   = lb_waddr_q;
    lb_wdata_d   = lb_wdata_q;
    line_done_d  = 1'b0;
    underrun_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d     = ST_REQ;
          ptr_d       = line_start;
          base_d      = line_start;
          bank_d      = tgt_line[0];
          burst_cnt_d = '0;
          word_cnt_d  = '0;
          line_idx_d  = '0;
        end
      end
      ST_REQ: begin
        if (deadline) begin
          underrun_set = 1'b1;
          ptr_d        = base_q + ADDR_W'(WPL);
          state_d      = ST_IDLE;
        end else if (rd_gnt) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rd_valid) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (!deadline) begin
            lb_we_d    = 1'b1;
            lb_waddr_d = line_idx_q;
            lb_wdata_d = rd_data;
            line_idx_d = line_idx_q + 9'd1;
            ptr_d      = ptr_q + 1'b1;
          end
        end
        if (deadline) begin
          underrun_set = 1'b1;
          ptr_d        = base_q + ADDR_W'(WPL);
          state_d      = (rd_valid && last_word) ? ST_IDLE : ST_DRAIN;
        end else if (rd_valid && last_word) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (burst_cnt_q == BCNT_W'(NBURST - 1)) begin
            line_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_DRAIN: begin
        // Words of the already-granted burst must still be consumed, but never written.
        if (rd_valid) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (last_word) state_d = ST_IDLE;
        end
        if (deadline) underrun_set = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (underrun_set)      underrun_d = 1'b1;
    else if (clr_underrun) underrun_d = 1'b0;
    else                   underrun_d = underrun_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= FB_BASE;
      base_q      <= FB_BASE;
      burst_cnt_q <= '0;
      word_cnt_q  <= '0;
      line_idx_q  <= '0;
      bank_q      <= 1'b0;
      lb_we_q     <= 1'b0;
      lb_waddr_q  <= '0;
      lb_wdata_q  <= '0;
      line_done_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      base_q      <= base_d;
      burst_cnt_q <= burst_cnt_d;
      word_cnt_q  <= word_cnt_d;
      line_idx_q  <= line_idx_d;
      bank_q      <= bank_d;
      lb_we_q     <= lb_we_d;
      lb_waddr_q  <= lb_waddr_d;
      lb_wdata_q  <= lb_wdata_d;
      line_done_q <= line_done_d;
      underrun_q  <= underrun_d;
    end
  end

  assign rd_req     = (state_q == ST_REQ);
  assign rd_addr    = rd_req ? ptr_q : '0;
  assign fetch_busy = (state_q != ST_IDLE);
  assign lb_we      = lb_we_q;
  assign lb_bank    = bank_q;
  assign lb_waddr   = lb_waddr_q;
  assign lb_wdata   = lb_wdata_q;
  assign line_done  = line_done_q;
  assign underrun   = underrun_q;
  assign rd_bank    = v_counter[0];
  assign rd_waddr   = (h_counter < 12'(H_DISPLAY)) ? 9'(h_counter / 12'(PIX_PER_WORD)) : 9'd0;

endmodule

// File: tb/tb_vga_line_fetch_ctrl.sv
// Randomized directed bench for the line prefetch controller against a line-level reference model.
// A behavioural memory answers bursts with address-derived data; a monitor logs requests and buffer writes.
module tb_vga_line_fetch_ctrl;

  logic        clk, rst_n;
  logic [11:0] h_counter;
  logic [10:0] v_counter;
  logic        rd_req, rd_gnt, rd_valid;
  logic [23:0] rd_addr;
  logic [47:0] rd_data, lb_wdata;
  logic        lb_we, lb_bank, rd_bank, fetch_busy, line_done, underrun, clr_underrun;
  logic [8:0]  lb_waddr, rd_waddr;

  vga_line_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .h_counter(h_counter), .v_counter(v_counter),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .lb_we(lb_we), .lb_bank(lb_bank), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata),
    .rd_bank(rd_bank), .rd_waddr(rd_waddr), .fetch_busy(fetch_busy), .line_done(line_done),
    .underrun(underrun), .clr_underrun(clr_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int gnt_delay = 0, word_gap = 0;
  logic [23:0] salt;
  bit clr_at_dl = 0;

  logic [8:0]  wq_addr[$];
  logic [47:0] wq_data[$];
  logic        wq_bank[$];
  logic [23:0] rq_addr[$];
  int          req_runs[$];
  int done_cnt, spur_we, addr_jump, scan_bad, wr_at_uf, run_len;
  logic prev_valid = 0, prev_req = 0, prev_under = 0;
  logic [23:0] prev_addr = '0;
  logic first_req, first_busy;
  logic [23:0] first_addr;

  function automatic logic [47:0] mem_word(input logic [23:0] a);
    return {a ^ salt, ~a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural memory: grant after gnt_delay cycles, then 16 words spaced word_gap idle cycles apart.
  int m_st = 0, m_wait = 0, m_words = 0, m_gap = 0;
  logic [23:0] m_addr = '0;
  initial begin
    rd_gnt = 1'b0; rd_valid = 1'b0; rd_data = '0;
    forever begin
      @(posedge clk); #1;
      rd_gnt = 1'b0; rd_valid = 1'b0;
      if (!rst_n) m_st = 0;
      else if (m_st == 2) begin
        if (m_gap == 0) begin
          rd_valid = 1'b1;
          rd_data  = mem_word(m_addr + 24'(m_words));
          m_words++;
          m_gap = word_gap;
          if (m_words == 16) m_st = 0;
        end else m_gap--;
      end else if (rd_req) begin
        if (m_st == 0) begin m_addr = rd_addr; m_wait = gnt_delay; m_st = 1; end
        if (m_wait == 0) begin rd_gnt = 1'b1; m_st = 2; m_words = 0; m_gap = 0; end
        else m_wait--;
      end else m_st = 0;
    end
  end

  // Monitor: logs accepted requests and buffer writes, flags writes without a preceding word.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (lb_we) begin
        wq_addr.push_back(lb_waddr); wq_data.push_back(lb_wdata); wq_bank.push_back(lb_bank);
        if (!prev_valid) spur_we++;
      end
      if (underrun && !prev_under) wr_at_uf = wq_addr.size();
      if (line_done) done_cnt++;
      if (rd_req) begin
        run_len++;
        if (prev_req && rd_addr !== prev_addr) addr_jump++;
        if (rd_gnt) begin rq_addr.push_back(rd_addr); req_runs.push_back(run_len); run_len = 0; end
      end else run_len = 0;
      prev_req = rd_req; prev_addr = rd_addr; prev_valid = rd_valid; prev_under = underrun;
    end
  end

  task automatic clear_log();
    wq_addr.delete(); wq_data.delete(); wq_bank.delete(); rq_addr.delete(); req_runs.delete();
    done_cnt = 0; spur_we = 0; addr_jump = 0; scan_bad = 0; wr_at_uf = -1; run_len = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (h_counter == 12'd2199) begin
      h_counter = 12'd0;
      v_counter = (v_counter == 11'd1124) ? 11'd0 : v_counter + 11'd1;
    end else h_counter = h_counter + 12'd1;
    clr_underrun = clr_at_dl && (h_counter == 12'd2199);
    #2;
    if (rd_waddr !== ((h_counter < 12'd1920) ? 9'(h_counter / 12'd4) : 9'd0) || rd_bank !== v_counter[0])
      scan_bad++;
  endtask

  task automatic start_line(input int vv);
    @(posedge clk); #1; h_counter = 12'd0; v_counter = 11'(vv); #2;
  endtask

  task automatic park();
    @(posedge clk); #1; h_counter = 12'd2000; clr_underrun = 1'b0; #2;
  endtask

  task automatic run_fetch(input int vv, input int max_cyc);
    int cyc;
    clear_log();
    start_line(vv);
    tick(); cyc = 1;
    first_req = rd_req; first_addr = rd_addr; first_busy = fetch_busy;
    while ((fetch_busy || cyc < 3) && cyc < max_cyc) begin tick(); cyc++; end
    chk("fetch_ends", {63'd0, fetch_busy}, 64'd0);
    park();
  endtask

  // Reference: line L comes from 30 bursts at L*480+16k, written to words 0..479 of bank L[0].
  task automatic check_line(input string tag, input int line);
    int bad = 0, rbad = 0;
    chk({tag, "_nreq"}, 64'(rq_addr.size()), 64'd30);
    foreach (rq_addr[k]) if (rq_addr[k] !== 24'(line * 480 + 16 * k)) bad++;
    chk({tag, "_req_addr"}, 64'(bad), 64'd0);
    chk({tag, "_nwr"}, 64'(wq_addr.size()), 64'd480);
    bad = 0;
    foreach (wq_addr[i])
      if (wq_addr[i] !== 9'(i) || wq_data[i] !== mem_word(24'(line * 480 + i)) || wq_bank[i] !== 1'(line % 2)) bad++;
    chk({tag, "_wr_data"}, 64'(bad), 64'd0);
    chk({tag, "_line_done"}, 64'(done_cnt), 64'd1);
    foreach (req_runs[k]) if (req_runs[k] != gnt_delay + 1) rbad++;
    chk({tag, "_req_hold"}, 64'(rbad + addr_jump), 64'd0);
    chk({tag, "_spur_we"}, 64'(spur_we), 64'd0);
    chk({tag, "_scanout"}, 64'(scan_bad), 64'd0);
  endtask

  initial begin
    int vv, n, bad, cyc;
    rst_n = 1'b1; h_counter = 12'd2000; v_counter = 11'd0; clr_underrun = 1'b0;
    salt = 24'($urandom);
    clear_log();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_outs", {rd_req, rd_addr, lb_we, lb_bank, lb_waddr, lb_wdata, fetch_busy, line_done, underrun},
        '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Line 1 from v=0, immediate grant, back-to-back data
    run_fetch(0, 2100);
    chk("t1_first_req", {first_req, first_busy, first_addr}, {1'b1, 1'b1, 24'd480});
    check_line("t1", 1);
    chk("t1_underrun", {63'd0, underrun}, 64'd0);

    // Random visible line with random grant latency and word spacing
    vv = $urandom_range(0, 1077); gnt_delay = $urandom_range(0, 3); word_gap = $urandom_range(0, 1);
    run_fetch(vv, 2100);
    check_line("t1r", vv + 1);

    gnt_delay = 0; word_gap = 0;
    run_fetch(1124, 2100);
    chk("t2_first_addr", {first_req, first_addr}, {1'b1, 24'd0});
    check_line("t2_wrap", 0);
    run_fetch(1079, 50);
    chk("t2_noreq_1079", 64'(rq_addr.size() + wq_addr.size()) | 64'(first_busy), 64'd0);
    run_fetch($urandom_range(1080, 1123), 50);
    chk("t2_noreq_vblank", 64'(rq_addr.size() + wq_addr.size()) | 64'(first_busy), 64'd0);

    // Grant held off 5 cycles on every burst
    gnt_delay = 5;
    vv = $urandom_range(0, 1077);
    run_fetch(vv, 2100);
    check_line("t3", vv + 1);

    // 1 word per 5 clocks cannot finish a line: underrun, drained tail, lost trigger
    gnt_delay = 0; word_gap = 4;
    vv = $urandom_range(0, 1070);
    run_fetch(vv, 2600);
    n = wq_addr.size();
    chk("t4_underrun", {63'd0, underrun}, 64'd1);
    chk("t4_partial", 64'(n > 0 && n < 480), 64'd1);
    chk("t4_no_wr_after", 64'(wr_at_uf), 64'(n));
    bad = 0;
    foreach (wq_addr[i]) if (wq_addr[i] !== 9'(i) || wq_data[i] !== mem_word(24'((vv + 1) * 480 + i))) bad++;
    chk("t4_wr_data", 64'(bad), 64'd0);
    chk("t4_nreq", 64'(rq_addr.size()), 64'((n + 15) / 16));
    chk("t4_no_done", 64'(done_cnt), 64'd0);
    word_gap = 0;
    run_fetch(vv + 1, 2100);
    chk("t4_ptr_next", {40'd0, first_addr}, 64'((vv + 2) * 480));
    check_line("t4_next", vv + 2);
    chk("t4_sticky", {63'd0, underrun}, 64'd1);

    // Clear alone, then clear colliding with a fresh miss
    @(posedge clk); #1 clr_underrun = 1'b1;
    @(posedge clk); #1 clr_underrun = 1'b0;
    #2 chk("t5_clr_alone", {63'd0, underrun}, 64'd0);
    word_gap = 4; clr_at_dl = 1;
    run_fetch($urandom_range(0, 1070), 2600);
    clr_at_dl = 0; word_gap = 0;
    chk("t5_set_wins", {63'd0, underrun}, 64'd1);

    // Reset in the middle of a burst, then a clean restart
    vv = $urandom_range(0, 1077);
    clear_log();
    start_line(vv);
    cyc = 0;
    while (wq_addr.size() < 7 && cyc < 300) begin tick(); cyc++; end
    chk("t6_reach_word7", 64'(wq_addr.size() >= 7), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_now", {61'd0, rd_req, lb_we, fetch_busy}, 64'd0);
    chk("t6_rst_flags", {62'd0, underrun, line_done}, 64'd0);
    repeat (3) @(posedge clk);
    #1 h_counter = 12'd2000; rst_n = 1'b1;
    run_fetch(vv, 2100);
    check_line("t6_restart", vv + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, observed no end, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
